// File: rtl/spi_frame_deserializer.sv
// SPI mode-0 slave front end: oversamples host pins in the clk domain, assembles
// MOSI frames into spi_out and shifts the spi_slave response back out on MISO.
module spi_frame_deserializer #(
    parameter int unsigned FRAME_BITS  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [16:0]           spi_in,
    output logic [FRAME_BITS:0]   spi_out,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned VLD_W = SYNC_STAGES + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_n_sync, mosi_sync;
    logic                   sclk_d, cs_n_d;
    logic [VLD_W-1:0]       vld_sr;
    logic                   armed;

    logic                   sclk_s, cs_n_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [FRAME_BITS-1:0]  rx_sr, rx_nxt;
    logic [FRAME_BITS-1:0]  tx_sr, tx_nxt;
    logic [CNT_W-1:0]       bitcnt, bitcnt_nxt;
    logic                   miso_nxt;
    logic [FRAME_BITS:0]    spi_out_nxt;
    logic                   frame_err_nxt;
    logic [ERR_W-1:0]       err_count_nxt;

    // Pin synchronisers plus one history flop; they clear to the idle pin levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_n_sync <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_n_d    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_n_d    <= cs_n_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;
    assign cs_fall   = ~cs_n_s & cs_n_d;

    // The reset-forced cs_n high level is not real; arm only once a genuine
    // high has travelled through the whole chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            armed  <= 1'b0;
        end else begin
            vld_sr <= {vld_sr[VLD_W-2:0], 1'b1};
            if (vld_sr[VLD_W-1] && cs_n_d && cs_n_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_sr     <= '0;
            tx_sr     <= '0;
            bitcnt    <= '0;
            miso      <= 1'b0;
            spi_out   <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_nxt;
            rx_sr     <= rx_nxt;
            tx_sr     <= tx_nxt;
            bitcnt    <= bitcnt_nxt;
            miso      <= miso_nxt;
            spi_out   <= spi_out_nxt;
            frame_err <= frame_err_nxt;
            err_count <= err_count_nxt;
        end
    end

    // cs_n edges take priority over any sclk edge detected on the same clk.
    always_comb begin
        state_nxt     = state_q;
        rx_nxt        = rx_sr;
        tx_nxt        = tx_sr;
        bitcnt_nxt    = bitcnt;
        miso_nxt      = miso;
        spi_out_nxt   = spi_out;
        frame_err_nxt = 1'b0;
        err_count_nxt = err_count;

        case (state_q)
            IDLE: begin
                miso_nxt = 1'b0;
                if (armed && cs_fall) begin
                    state_nxt  = SHIFT;
                    tx_nxt     = FRAME_BITS'(spi_in);
                    bitcnt_nxt = '0;
                    miso_nxt   = tx_nxt[FRAME_BITS-1];
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    miso_nxt  = 1'b0;
                    if (bitcnt == CNT_W'(FRAME_BITS)) begin
                        spi_out_nxt = {~spi_out[FRAME_BITS], rx_sr};
                    end else begin
                        frame_err_nxt = 1'b1;
                        if (err_count != '1) begin
                            err_count_nxt = err_count + ERR_W'(1);
                        end
                    end
                end else if (sclk_rise) begin
                    rx_nxt = {rx_sr[FRAME_BITS-2:0], mosi_s};
                    if (bitcnt != '1) begin
                        bitcnt_nxt = bitcnt + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    tx_nxt   = {tx_sr[FRAME_BITS-2:0], 1'b0};
                    miso_nxt = tx_sr[FRAME_BITS-2];
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
